// File: rtl/modbus_pkg.sv
// Shared types, constants and the CRC-16/MODBUS byte-update helper for the
// Modbus RTU receive path.
package modbus_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RX   = 2'd2,
        ST_GAP  = 2'd3
    } rx_state_e;

    localparam int         MIN_FRAME_LEN = 4;
    localparam logic [7:0] BCAST_ADDR    = 8'h00;

    // t1.5 / t3.5 in 50 MHz clock cycles for an 11-bit character
    localparam int T15_CYC_9600  = 85938;
    localparam int T35_CYC_9600  = 200521;
    localparam int T15_CYC_19200 = 42969;
    localparam int T35_CYC_19200 = 100260;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

    function automatic logic [15:0] crc16_update(input logic [15:0] crc,
                                                 input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_modbus.sv
// Byte-wide CRC-16/MODBUS accumulator (reflected 0xA001, init 0xFFFF).
// crc_o reflects every byte accepted up to the previous clock.
module crc16_modbus (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);
    import modbus_pkg::*;

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Next CRC value: clear wins over a data update
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC_INIT;
        end else if (valid_i) begin
            crc_d = crc16_update(crc_q, data_i);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/modbus_rx_framer.sv
// Modbus RTU receive framer: t1.5/t3.5 frame delimiting, CRC residue check and
// per-frame status. Define MODBUS_RX_STATS_EN to build the CRC/gap error counters.
module modbus_rx_framer
    import modbus_pkg::*;
#(
    parameter int T15_CYC = T15_CYC_19200,
    parameter int T35_CYC = T35_CYC_19200,
    parameter int MAX_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        rx_err_i,
    input  logic [7:0]  my_addr_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        sof_o,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic [8:0]  frame_len_o,
    output logic        addr_match_o,
    output logic        bcast_o,
    output logic        busy_o,
    output logic [15:0] crc_err_cnt_o,
    output logic [15:0] gap_err_cnt_o
);

    localparam int                TMR_W     = $clog2(T35_CYC + 1);
    localparam logic [TMR_W-1:0]  T15_T     = TMR_W'(T15_CYC);
    localparam logic [TMR_W-1:0]  T35_T     = TMR_W'(T35_CYC);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
    localparam logic [8:0]        MAX_LEN_T = 9'(MAX_LEN);
    localparam logic [8:0]        MIN_LEN_T = 9'(MIN_FRAME_LEN);

    rx_state_e         state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [8:0]        len_q, len_d;
    logic [7:0]        addr_q, addr_d;
    logic              gap_err_q, gap_err_d;
    logic              ovf_q, ovf_d;
    logic              byte_err_q, byte_err_d;
    logic [7:0]        byte_q, byte_d;
    logic              byte_valid_q, byte_valid_d;
    logic              sof_q, sof_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic [8:0]        flen_q, flen_d;
    logic              match_q, match_d;
    logic              bcast_q, bcast_d;
    logic              busy_q, busy_d;
    logic              eof_s;
    logic              crc_clr_s;
    logic              crc_valid_s;
    logic [15:0]       crc_s;

    crc16_modbus u_crc (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (crc_clr_s),
        .valid_i (crc_valid_s),
        .data_i  (rx_data_i),
        .crc_o   (crc_s)
    );

    // Framing FSM, silence timer, sticky flags and output next-state
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        gap_err_d    = gap_err_q;
        ovf_d        = ovf_q;
        byte_err_d   = byte_err_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        sof_d        = 1'b0;
        done_d       = 1'b0;
        ok_d         = ok_q;
        flen_d       = flen_q;
        match_d      = match_q;
        bcast_d      = bcast_q;
        eof_s        = 1'b0;
        crc_clr_s    = 1'b0;
        crc_valid_s  = 1'b0;

        // Any strobe restarts the silence timer, which saturates at t3.5
        if (rx_valid_i) begin
            timer_d = {TMR_W{1'b0}};
        end else if (timer_q != T35_T) begin
            timer_d = timer_q + TMR_ONE;
        end else begin
            timer_d = timer_q;
        end

        case (state_q)
            ST_INIT: begin
                if (!rx_valid_i && (timer_q == T35_T)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (rx_valid_i) begin
                    state_d      = ST_RX;
                    len_d        = 9'd1;
                    addr_d       = rx_data_i;
                    gap_err_d    = 1'b0;
                    ovf_d        = 1'b0;
                    byte_err_d   = rx_err_i;
                    byte_d       = rx_data_i;
                    byte_valid_d = 1'b1;
                    sof_d        = 1'b1;
                    crc_valid_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RX, ST_GAP: begin
                if (rx_valid_i) begin
                    byte_err_d = byte_err_q | rx_err_i;
                    if (state_q == ST_GAP) begin
                        gap_err_d = 1'b1;
                    end else begin
                        gap_err_d = gap_err_q;
                    end
                    // A full frame drops further bytes entirely
                    if (len_q == MAX_LEN_T) begin
                        ovf_d = 1'b1;
                    end else begin
                        len_d        = len_q + 9'd1;
                        byte_d       = rx_data_i;
                        byte_valid_d = 1'b1;
                        crc_valid_s  = 1'b1;
                    end
                end else if ((state_q == ST_RX) && (timer_q == T15_T)) begin
                    state_d = ST_GAP;
                end else if ((state_q == ST_GAP) && (timer_q == T35_T)) begin
                    state_d = ST_IDLE;
                    eof_s   = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (eof_s) begin
            crc_clr_s  = 1'b1;
            done_d     = 1'b1;
            ok_d       = (crc_s == 16'h0000) && !gap_err_q && !ovf_q &&
                         !byte_err_q && (len_q >= MIN_LEN_T);
            flen_d     = len_q;
            match_d    = (addr_q == my_addr_i) || (addr_q == BCAST_ADDR);
            bcast_d    = (addr_q == BCAST_ADDR);
            len_d      = 9'd0;
            gap_err_d  = 1'b0;
            ovf_d      = 1'b0;
            byte_err_d = 1'b0;
        end else begin
            done_d = 1'b0;
        end

        busy_d = (state_d == ST_RX) || (state_d == ST_GAP);
    end

    // State, timer, frame context and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            timer_q      <= {TMR_W{1'b0}};
            len_q        <= 9'd0;
            addr_q       <= 8'h00;
            gap_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            byte_err_q   <= 1'b0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            flen_q       <= 9'd0;
            match_q      <= 1'b0;
            bcast_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            gap_err_q    <= gap_err_d;
            ovf_q        <= ovf_d;
            byte_err_q   <= byte_err_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            sof_q        <= sof_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            flen_q       <= flen_d;
            match_q      <= match_d;
            bcast_q      <= bcast_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MODBUS_RX_STATS_EN
    logic [15:0] crc_cnt_q;
    logic [15:0] gap_cnt_q;

    // Saturating per-frame error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_cnt_q <= 16'h0000;
            gap_cnt_q <= 16'h0000;
        end else begin
            if (eof_s && (crc_s != 16'h0000) && (crc_cnt_q != 16'hFFFF)) begin
                crc_cnt_q <= crc_cnt_q + 16'd1;
            end
            if (eof_s && gap_err_q && (gap_cnt_q != 16'hFFFF)) begin
                gap_cnt_q <= gap_cnt_q + 16'd1;
            end
        end
    end

    assign crc_err_cnt_o = crc_cnt_q;
    assign gap_err_cnt_o = gap_cnt_q;
`else
    assign crc_err_cnt_o = 16'h0000;
    assign gap_err_cnt_o = 16'h0000;
`endif

    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign sof_o        = sof_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign frame_len_o  = flen_q;
    assign addr_match_o = match_q;
    assign bcast_o      = bcast_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_modbus_rx_framer.sv
// Directed bench for modbus_rx_framer: table of frames plus hand-written
// sequences for INIT, timeout-cycle and mid-frame reset corner cases.
module tb_modbus_rx_framer;

    localparam int T15   = 15;
    localparam int T35   = 35;
    localparam int MAXL  = 16;
    localparam int SPACE = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data_i = 8'h00;
    logic        rx_valid_i = 1'b0;
    logic        rx_err_i = 1'b0;
    logic [7:0]  my_addr_i = 8'h01;
    logic [7:0]  byte_o;
    logic        byte_valid_o;
    logic        sof_o;
    logic        frame_done_o;
    logic        frame_ok_o;
    logic [8:0]  frame_len_o;
    logic        addr_match_o;
    logic        bcast_o;
    logic        busy_o;
    logic [15:0] crc_err_cnt_o;
    logic [15:0] gap_err_cnt_o;

    modbus_rx_framer #(.T15_CYC(T15), .T35_CYC(T35), .MAX_LEN(MAXL)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data_i     (rx_data_i),
        .rx_valid_i    (rx_valid_i),
        .rx_err_i      (rx_err_i),
        .my_addr_i     (my_addr_i),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .sof_o         (sof_o),
        .frame_done_o  (frame_done_o),
        .frame_ok_o    (frame_ok_o),
        .frame_len_o   (frame_len_o),
        .addr_match_o  (addr_match_o),
        .bcast_o       (bcast_o),
        .busy_o        (busy_o),
        .crc_err_cnt_o (crc_err_cnt_o),
        .gap_err_cnt_o (gap_err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [143:0] bytes;     // byte 0 in the top 8 bits
        int           n;
        int           crc_pos;   // >=0: bench writes CRC of bytes[0..crc_pos-1] here
        int           gap_idx;
        int           gap_len;
        int           err_idx;
        logic [7:0]   addr;
        logic         exp_ok;
        int           exp_len;
        logic         exp_match;
        logic         exp_bcast;
        int           crc_inc;
        int           gap_inc;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         sof_cnt = 0;
    int         last_strobe = 0;
    logic [7:0] sof_byte = 8'h00;
    logic [7:0] fwd_q [$];
    vec_t       vecs [9];

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor of DUT outputs, sampled on the falling edge
    always @(negedge clk) begin
        if (frame_done_o) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (byte_valid_o) begin
            fwd_q.push_back(byte_o);
            if (sof_o) begin
                sof_cnt  <= sof_cnt + 1;
                sof_byte <= byte_o;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e);
        rx_data_i   = b;
        rx_err_i    = e;
        rx_valid_i  = 1'b1;
        last_strobe = cyc + 1;
        step(1);
        rx_valid_i  = 1'b0;
        rx_err_i    = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit got);
        got = 1'b0;
        for (int t = 0; t < 80 && !got; t++) begin
            step(1);
            if (done_cnt != d0) got = 1'b1;
        end
    endtask

    // Bit-serial CRC-16/MODBUS reference
    function automatic logic [15:0] ref_crc(input logic [7:0] b [18], input int n);
        logic [15:0] c;
        logic        fbk;
        c = 16'hFFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) begin
                fbk = c[0] ^ b[k][j];
                c   = {1'b0, c[15:1]};
                if (fbk) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [7:0]  fb [18];
        logic [15:0] c;
        int          d0, crc0, gap0, sof0, fwd0, nfwd, bad, sp;
        int          exp_crc, exp_gap;
        bit          got;
        for (int i = 0; i < 18; i++) fb[i] = v.bytes[(17 - i) * 8 +: 8];
        if (v.crc_pos >= 0) begin
            c = ref_crc(fb, v.crc_pos);
            fb[v.crc_pos]     = c[7:0];
            fb[v.crc_pos + 1] = c[15:8];
        end
        my_addr_i = v.addr;
        d0   = done_cnt;
        crc0 = int'(crc_err_cnt_o);
        gap0 = int'(gap_err_cnt_o);
        sof0 = sof_cnt;
        fwd0 = fwd_q.size();
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) begin
                sp = (i == v.gap_idx) ? v.gap_len : SPACE;
                step(sp - 1);
            end
            send_byte(fb[i], (i == v.err_idx));
        end
        wait_done(d0, got);
        check({v.name, "_done_seen"}, 64'(got), 64'(1));
        if (got) begin
`ifdef MODBUS_RX_STATS_EN
            exp_crc = crc0 + v.crc_inc;
            exp_gap = gap0 + v.gap_inc;
`else
            exp_crc = 0;
            exp_gap = 0;
`endif
            check({v.name, "_latency"}, 64'(done_cyc - last_strobe), 64'(36));
            check({v.name, "_ok"},      64'(frame_ok_o),   64'(v.exp_ok));
            check({v.name, "_len"},     64'(frame_len_o),  64'(v.exp_len));
            check({v.name, "_match"},   64'(addr_match_o), 64'(v.exp_match));
            check({v.name, "_bcast"},   64'(bcast_o),      64'(v.exp_bcast));
            check({v.name, "_crc_cnt"}, 64'(crc_err_cnt_o), 64'(exp_crc));
            check({v.name, "_gap_cnt"}, 64'(gap_err_cnt_o), 64'(exp_gap));
            check({v.name, "_sof_cnt"}, 64'(sof_cnt - sof0), 64'(1));
            check({v.name, "_sof_byte"}, 64'(sof_byte), 64'(fb[0]));
            nfwd = (v.n < MAXL) ? v.n : MAXL;
            check({v.name, "_fwd_cnt"}, 64'(fwd_q.size() - fwd0), 64'(nfwd));
            bad = 0;
            for (int i = 0; i < nfwd && (fwd0 + i) < fwd_q.size(); i++) begin
                if (fwd_q[fwd0 + i] !== fb[i]) bad++;
            end
            check({v.name, "_fwd_data_bad"}, 64'(bad), 64'(0));
            step(1);
            check({v.name, "_done_width"}, 64'(frame_done_o), 64'(0));
            check({v.name, "_done_cnt"},   64'(done_cnt - d0), 64'(1));
            check({v.name, "_busy_idle"},  64'(busy_o), 64'(0));
            check({v.name, "_ok_hold"},    64'(frame_ok_o), 64'(v.exp_ok));
        end
        step(3);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({byte_o, byte_valid_o, sof_o, frame_done_o, frame_ok_o, frame_len_o,
                    addr_match_o, bcast_o, busy_o, crc_err_cnt_o, gap_err_cnt_o});
    endfunction

    initial begin : main
        int  d0, gap0, fwd0;
        bit  got;
        vecs[0] = '{"clean",   {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 80'h0},
                    8, -1, -1, 0, -1, 8'h01, 1'b1, 8, 1'b1, 1'b0, 0, 0};
        vecs[1] = '{"corrupt", {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCC, 80'h0},
                    8, -1, -1, 0, -1, 8'h01, 1'b0, 8, 1'b1, 1'b0, 1, 0};
        vecs[2] = '{"gap",     {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 80'h0},
                    8, -1, 4, 20, -1, 8'h01, 1'b0, 8, 1'b1, 1'b0, 0, 1};
        vecs[3] = '{"bcast",   {8'h00, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 96'h0},
                    8, 6, -1, 0, -1, 8'h01, 1'b1, 8, 1'b1, 1'b1, 0, 0};
        vecs[4] = '{"ovf",     {8'h05, 8'h10, 8'h00, 8'h01, 8'h00, 8'h05, 8'h0A, 8'h11, 8'h22,
                                8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 16'h0000, 8'hAB, 8'hCD},
                    18, 14, -1, 0, -1, 8'h01, 1'b0, 16, 1'b0, 1'b0, 0, 0};
        vecs[5] = '{"short3",  {8'h01, 136'h0},
                    3, 1, -1, 0, -1, 8'h01, 1'b0, 3, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{"min4",    {8'h11, 8'h22, 128'h0},
                    4, 2, -1, 0, -1, 8'h11, 1'b1, 4, 1'b1, 1'b0, 0, 0};
        vecs[7] = '{"byte_err", {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 80'h0},
                    8, -1, -1, 0, 2, 8'h01, 1'b0, 8, 1'b1, 1'b0, 0, 0};
        vecs[8] = '{"other_addr", {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD, 80'h0},
                    8, -1, -1, 0, -1, 8'h02, 1'b1, 8, 1'b0, 1'b0, 0, 0};

        step(3);
        check("reset_outputs", all_outs(), 64'(0));
        rst = 1'b0;

        // Bytes during INIT are dropped and restart the t3.5 wait
        step(29);
        send_byte(8'h01, 1'b0);
        step(29);
        send_byte(8'h01, 1'b0);
        step(5);
        check("init_no_fwd",  64'(fwd_q.size()), 64'(0));
        check("init_no_busy", 64'(busy_o), 64'(0));
        step(40);
        check("init_no_done", 64'(done_cnt), 64'(0));

        for (int k = 0; k < 9; k++) run_vec(vecs[k]);

        // Byte exactly on the t3.5 expiry cycle keeps the frame open
        my_addr_i = 8'h01;
        d0   = done_cnt;
        gap0 = int'(gap_err_cnt_o);
        fwd0 = fwd_q.size();
        send_byte(8'h01, 1'b0);
        step(35);
        send_byte(8'h02, 1'b0);
        step(2);
        check("tmo_no_done", 64'(done_cnt - d0), 64'(0));
        check("tmo_busy",    64'(busy_o), 64'(1));
        step(7);
        send_byte(8'h03, 1'b0);
        step(9);
        send_byte(8'h04, 1'b0);
        wait_done(d0, got);
        check("tmo_done_seen", 64'(got), 64'(1));
        check("tmo_latency", 64'(done_cyc - last_strobe), 64'(36));
        check("tmo_len",     64'(frame_len_o), 64'(4));
        check("tmo_ok",      64'(frame_ok_o), 64'(0));
        check("tmo_fwd_cnt", 64'(fwd_q.size() - fwd0), 64'(4));
`ifdef MODBUS_RX_STATS_EN
        check("tmo_gap_cnt", 64'(gap_err_cnt_o), 64'(gap0 + 1));
`else
        check("tmo_gap_cnt", 64'(gap_err_cnt_o), 64'(0));
`endif
        step(1);
        check("tmo_done_cnt", 64'(done_cnt - d0), 64'(1));
        step(3);

        // Reset in the middle of a frame
        send_byte(8'h01, 1'b0);
        step(9);
        send_byte(8'h03, 1'b0);
        step(9);
        send_byte(8'h00, 1'b0);
        step(2);
        rst = 1'b1;
        step(1);
        check("midrst_outputs", all_outs(), 64'(0));
        step(1);
        rst = 1'b0;
        d0 = done_cnt;
        step(80);
        check("midrst_no_done", 64'(done_cnt - d0), 64'(0));
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
